// File: rtl/program_counter_multiprocesso.sv
// Multi-process program counter with quantum-based preemption and a per-slot saved-PC table.
// Optional feature: define SALTO_RELATIVO_EN to make jump_prog=11 a PC-relative jump.
module program_counter_multiprocesso #(
  parameter int LARGURA_PC      = 32,
  parameter int NUM_PROC        = 4,
  parameter int LARGURA_QUANTUM = 5,
  localparam int LARGURA_IDX    = $clog2(NUM_PROC)
) (
  input  logic                       clock,
  input  logic                       reset_geral,
  input  logic                       modo_preemptivo,
  input  logic [LARGURA_QUANTUM-1:0] quantum,
  input  logic                       reset_cont_preempcao,
  input  logic                       halt,
  input  logic [1:0]                 jump_prog,
  input  logic [LARGURA_PC-1:0]      PC_in,
  input  logic                       wr_tab_en,
  input  logic [LARGURA_IDX-1:0]     wr_tab_idx,
  input  logic [LARGURA_PC-1:0]      wr_tab_dado,
  output logic [LARGURA_PC-1:0]      PC,
  output logic [LARGURA_PC-1:0]      PC_mais_1,
  output logic                       flag_faz_preempcao,
  output logic [LARGURA_PC-1:0]      salva_PC,
  output logic [LARGURA_IDX-1:0]     proc_atual
);

  logic [LARGURA_PC-1:0]      pc_reg;
  logic [LARGURA_PC-1:0]      salva_reg;
  logic [LARGURA_IDX-1:0]     proc_reg;
  logic [LARGURA_IDX-1:0]     proc_prox;
  logic [LARGURA_QUANTUM-1:0] cont;
  logic                       flag_reg;
  logic [LARGURA_PC-1:0]      tab [NUM_PROC];
  logic [LARGURA_PC-1:0]      next_pc;
  logic                       preempcao_ativa;
  logic                       troca;

  assign preempcao_ativa = modo_preemptivo && (quantum != '0);
  assign proc_prox       = proc_reg + LARGURA_IDX'(1);

  // ">=" rather than "==" so a quantum shrunk below the running count still switches next edge.
  assign troca = !halt && preempcao_ativa && !reset_cont_preempcao &&
                 (cont >= (quantum - LARGURA_QUANTUM'(1)));

  always_comb begin
    next_pc = pc_reg;
    case (jump_prog)
      2'b00:   next_pc = pc_reg + LARGURA_PC'(1);
      2'b01:   next_pc = PC_in;
      2'b10:   next_pc = tab[proc_reg];
      default: begin
`ifdef SALTO_RELATIVO_EN
        next_pc = pc_reg + PC_in;
`else
        next_pc = pc_reg;
`endif
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_geral) begin
      pc_reg    <= '0;
      salva_reg <= '0;
      proc_reg  <= '0;
      cont      <= '0;
      flag_reg  <= 1'b0;
      for (int i = 0; i < NUM_PROC; i++) begin
        tab[i] <= '0;
      end
    end else begin
      if (wr_tab_en) begin
        tab[wr_tab_idx] <= wr_tab_dado;
      end
      flag_reg <= 1'b0;
      if (!halt) begin
        if (troca) begin
          // Later assignment to the same slot overrides the external write above.
          tab[proc_reg] <= next_pc;
          salva_reg     <= next_pc;
          pc_reg        <= tab[proc_prox];
          proc_reg      <= proc_prox;
          cont          <= '0;
          flag_reg      <= 1'b1;
        end else begin
          pc_reg <= next_pc;
          if (!preempcao_ativa || reset_cont_preempcao) begin
            cont <= '0;
          end else begin
            cont <= cont + LARGURA_QUANTUM'(1);
          end
        end
      end
    end
  end

  assign PC                 = pc_reg;
  assign PC_mais_1          = pc_reg + LARGURA_PC'(1);
  assign flag_faz_preempcao = flag_reg;
  assign salva_PC           = salva_reg;
  assign proc_atual         = proc_reg;

endmodule

// File: tb/tb_program_counter_multiprocesso.sv
// Directed bench for program_counter_multiprocesso: expected state queued per step, checked after the edge.
module tb_program_counter_multiprocesso;

  logic        clock;
  logic        reset_geral;
  logic        modo_preemptivo;
  logic [4:0]  quantum;
  logic        reset_cont_preempcao;
  logic        halt;
  logic [1:0]  jump_prog;
  logic [31:0] PC_in;
  logic        wr_tab_en;
  logic [1:0]  wr_tab_idx;
  logic [31:0] wr_tab_dado;
  logic [31:0] PC;
  logic [31:0] PC_mais_1;
  logic        flag_faz_preempcao;
  logic [31:0] salva_PC;
  logic [1:0]  proc_atual;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  proc;
    logic        flag;
    logic [31:0] salva;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    checks = 0;
  int    errors = 0;
  logic [31:0] rel;

  program_counter_multiprocesso dut (
    .clock(clock),
    .reset_geral(reset_geral),
    .modo_preemptivo(modo_preemptivo),
    .quantum(quantum),
    .reset_cont_preempcao(reset_cont_preempcao),
    .halt(halt),
    .jump_prog(jump_prog),
    .PC_in(PC_in),
    .wr_tab_en(wr_tab_en),
    .wr_tab_idx(wr_tab_idx),
    .wr_tab_dado(wr_tab_dado),
    .PC(PC),
    .PC_mais_1(PC_mais_1),
    .flag_faz_preempcao(flag_faz_preempcao),
    .salva_PC(salva_PC),
    .proc_atual(proc_atual)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout no summary reached");
    $fatal(1, "timeout");
  end

  task automatic step(input string tag, input logic [1:0] jp, input logic [31:0] pin,
                      input logic [31:0] epc, input logic [1:0] eproc,
                      input logic eflag, input logic [31:0] esalva);
    exp_t  e;
    string t;
    jump_prog = jp;
    PC_in     = pin;
    exp_q.push_back('{pc: epc, proc: eproc, flag: eflag, salva: esalva});
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (PC === e.pc) else begin
      errors++;
      $error("FAIL %s PC observed %h expected %h", t, PC, e.pc);
    end
    checks++;
    assert (PC_mais_1 === e.pc + 32'd1) else begin
      errors++;
      $error("FAIL %s PC_mais_1 observed %h expected %h", t, PC_mais_1, e.pc + 32'd1);
    end
    checks++;
    assert (proc_atual === e.proc) else begin
      errors++;
      $error("FAIL %s proc_atual observed %0d expected %0d", t, proc_atual, e.proc);
    end
    checks++;
    assert (flag_faz_preempcao === e.flag) else begin
      errors++;
      $error("FAIL %s flag observed %b expected %b", t, flag_faz_preempcao, e.flag);
    end
    checks++;
    assert (salva_PC === e.salva) else begin
      errors++;
      $error("FAIL %s salva_PC observed %h expected %h", t, salva_PC, e.salva);
    end
  endtask

  initial begin
`ifdef SALTO_RELATIVO_EN
    rel = 32'h0C;
`else
    rel = 32'h10;
`endif
    reset_geral = 1'b0; halt = 1'b1; wr_tab_en = 1'b1; wr_tab_idx = 2'd2;
    wr_tab_dado = 32'h55; modo_preemptivo = 1'b1; quantum = 5'd1;
    reset_cont_preempcao = 1'b0; jump_prog = 2'b01; PC_in = 32'h77;
    step("reset", 2'b01, 32'h77, 32'h0, 2'd0, 1'b0, 32'h0);

    reset_geral = 1'b1; halt = 1'b0; wr_tab_en = 1'b0; modo_preemptivo = 1'b0; quantum = 5'd0;
    step("jmp_abs",   2'b01, 32'h5, 32'h5, 2'd0, 1'b0, 32'h0);
    step("ret_slot0", 2'b10, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
    step("seq_nopre", 2'b00, 32'h0, 32'h1, 2'd0, 1'b0, 32'h0);

    modo_preemptivo = 1'b1; quantum = 5'd1;
    step("q1_s0",  2'b01, 32'h9, 32'h0, 2'd1, 1'b1, 32'h9);
    step("q1_s1",  2'b01, 32'hA, 32'h0, 2'd2, 1'b1, 32'hA);
    step("q1_s2",  2'b01, 32'hB, 32'h0, 2'd3, 1'b1, 32'hB);
    step("q1_s3",  2'b01, 32'hC, 32'h9, 2'd0, 1'b1, 32'hC);
    step("q1_s0b", 2'b00, 32'h0, 32'hA, 2'd1, 1'b1, 32'hA);

    reset_geral = 1'b0;
    step("reset2", 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
    reset_geral = 1'b1;

    halt = 1'b1; wr_tab_en = 1'b1; wr_tab_idx = 2'd1; wr_tab_dado = 32'h100;
    modo_preemptivo = 1'b0; quantum = 5'd3;
    step("wr_halt", 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
    halt = 1'b0; wr_tab_en = 1'b0; modo_preemptivo = 1'b1;
    step("q3_a",     2'b00, 32'h0, 32'h1,   2'd0, 1'b0, 32'h0);
    step("q3_b",     2'b00, 32'h0, 32'h2,   2'd0, 1'b0, 32'h0);
    step("q3_sw",    2'b00, 32'h0, 32'h100, 2'd1, 1'b1, 32'h3);
    step("q3_after", 2'b00, 32'h0, 32'h101, 2'd1, 1'b0, 32'h3);

    halt = 1'b1;
    for (int i = 0; i < 5; i++) step("halt", 2'b00, 32'h0, 32'h101, 2'd1, 1'b0, 32'h3);
    halt = 1'b0;
    step("post_halt",    2'b00, 32'h0, 32'h102, 2'd1, 1'b0, 32'h3);
    step("post_halt_sw", 2'b00, 32'h0, 32'h0,   2'd2, 1'b1, 32'h103);

    step("s2_a",   2'b00, 32'h0,  32'h1, 2'd2, 1'b0, 32'h103);
    step("s2_b",   2'b00, 32'h0,  32'h2, 2'd2, 1'b0, 32'h103);
    step("jmp_sw", 2'b01, 32'h40, 32'h0, 2'd3, 1'b1, 32'h40);

    step("s3_a",  2'b00, 32'h0, 32'h1, 2'd3, 1'b0, 32'h40);
    step("s3_b",  2'b00, 32'h0, 32'h2, 2'd3, 1'b0, 32'h40);
    step("s3_sw", 2'b00, 32'h0, 32'h3, 2'd0, 1'b1, 32'h3);
    step("s0_a",  2'b00, 32'h0, 32'h4, 2'd0, 1'b0, 32'h3);
    step("s0_b",  2'b00, 32'h0, 32'h5, 2'd0, 1'b0, 32'h3);
    step("s0_sw", 2'b00, 32'h0, 32'h103, 2'd1, 1'b1, 32'h6);
    step("s1_a",  2'b00, 32'h0, 32'h104, 2'd1, 1'b0, 32'h6);
    step("s1_b",  2'b00, 32'h0, 32'h105, 2'd1, 1'b0, 32'h6);
    step("s1_sw", 2'b00, 32'h0, 32'h40,  2'd2, 1'b1, 32'h106);

    step("s2_jmp", 2'b01, 32'h7, 32'h7,  2'd2, 1'b0, 32'h106);
    step("s2_ret", 2'b10, 32'h0, 32'h40, 2'd2, 1'b0, 32'h106);
    reset_cont_preempcao = 1'b1;
    step("rst_cont", 2'b00, 32'h0, 32'h41, 2'd2, 1'b0, 32'h106);
    reset_cont_preempcao = 1'b0;
    step("cnt1", 2'b00, 32'h0, 32'h42, 2'd2, 1'b0, 32'h106);
    quantum = 5'd1;
    step("q_shrink_sw", 2'b00, 32'h0, 32'h3, 2'd3, 1'b1, 32'h43);

    modo_preemptivo = 1'b0;
    step("rel_setup", 2'b01, 32'h10, 32'h10, 2'd3, 1'b0, 32'h43);
    modo_preemptivo = 1'b1; quantum = 5'd2;
    step("rel_jump", 2'b11, 32'hFFFFFFFC, rel,   2'd3, 1'b0, 32'h43);
    step("rel_sw",   2'b00, 32'h0,        32'h6, 2'd0, 1'b1, rel + 32'd1);

    quantum = 5'd0;
    step("q0_a", 2'b00, 32'h0, 32'h7, 2'd0, 1'b0, rel + 32'd1);
    step("q0_b", 2'b00, 32'h0, 32'h8, 2'd0, 1'b0, rel + 32'd1);
    step("q0_c", 2'b00, 32'h0, 32'h9, 2'd0, 1'b0, rel + 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
